// File: rtl/black_box_constant_checker.sv
// Stream checker: accepts COUNT valid/ready words, compares each against VALUE, reports done/pass/mismatches.
// Optional first-mismatch capture outputs are built when BLACK_BOX_CHECKER_CAPTURE_EN is defined.
module black_box_constant_checker #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned VALUE = 1,
  parameter int unsigned COUNT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       mismatches
`ifdef BLACK_BOX_CHECKER_CAPTURE_EN
  ,
  output logic             first_bad_valid,
  output logic [7:0]       first_bad_index,
  output logic [WIDTH-1:0] first_bad_bits
`endif
);

  localparam int unsigned CW = $clog2(COUNT + 1);
  localparam logic [WIDTH-1:0] EXP = WIDTH'(VALUE);
  localparam logic [CW-1:0] LAST_IDX = CW'(COUNT - 1);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          hs, bad, last, enter;
  logic [7:0]    mis_inc;

  assign in_ready = (state_q == CHECK);
  assign hs       = in_valid & in_ready;
  assign bad      = (in_bits != EXP);
  assign last     = (cnt_q == LAST_IDX);
  assign mis_inc  = (mismatches == 8'hFF) ? mismatches : mismatches + 8'd1;
  assign enter    = (state_q != CHECK) && (state_d == CHECK);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // start is only honoured outside CHECK, so a start that coincides with the final word is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CHECK;
      CHECK:   if (hs && last) state_d = DONE;
      DONE:    if (start) state_d = CHECK;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      mismatches <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      busy <= (state_d == CHECK);
      if (enter) begin
        cnt_q      <= '0;
        mismatches <= '0;
        done       <= 1'b0;
        pass       <= 1'b0;
      end else if (hs) begin
        cnt_q <= cnt_q + 1'b1;
        if (bad) mismatches <= mis_inc;
        if (last) begin
          done <= 1'b1;
          // final word's verdict folds in here since mismatches has not yet absorbed it
          pass <= (mismatches == 8'd0) && !bad;
        end
      end
    end
  end

`ifdef BLACK_BOX_CHECKER_CAPTURE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_bad_valid <= 1'b0;
      first_bad_index <= '0;
      first_bad_bits  <= '0;
    end else if (enter) begin
      first_bad_valid <= 1'b0;
      first_bad_index <= '0;
      first_bad_bits  <= '0;
    end else if (hs && bad && !first_bad_valid) begin
      first_bad_valid <= 1'b1;
      first_bad_index <= 8'(cnt_q);
      first_bad_bits  <= in_bits;
    end
  end
`endif

endmodule

// File: tb/tb_black_box_constant_checker.sv
// Bench for black_box_constant_checker: directed scenarios plus randomized runs against an integer-level run model.
module tb_black_box_constant_checker;

  localparam int W = 16;
  localparam int V = 1;
  localparam int N = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0, in_valid = 1'b0;
  logic [W-1:0]  in_bits = '0;
  logic          in_ready, busy, done, pass;
  logic [7:0]    mismatches;
  logic          start2 = 1'b0, in_valid2 = 1'b0;
  logic [W-1:0]  in_bits2 = '0;
  logic          in_ready2, busy2, done2, pass2;
  logic [7:0]    mismatches2;
`ifdef BLACK_BOX_CHECKER_CAPTURE_EN
  logic          fb_valid, fb_valid2;
  logic [7:0]    fb_index, fb_index2;
  logic [W-1:0]  fb_bits, fb_bits2;
`endif

  int compared = 0;
  int mismatched = 0;
  int busy_cnt = 0;

  // run model: a run is just "how many words seen, how many were wrong"
  bit          m_run = 0, m_done = 0, m_pass = 0;
  int          m_cnt = 0, m_bad = 0;
  bit          m_fb_valid = 0;
  int          m_fb_idx = 0;
  logic [W-1:0] m_fb_bits = '0;

  always #5 clock = ~clock;

  black_box_constant_checker #(.WIDTH(W), .VALUE(V), .COUNT(N)) u_dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_bits(in_bits), .busy(busy), .done(done), .pass(pass), .mismatches(mismatches)
`ifdef BLACK_BOX_CHECKER_CAPTURE_EN
    , .first_bad_valid(fb_valid), .first_bad_index(fb_index), .first_bad_bits(fb_bits)
`endif
  );

  black_box_constant_checker #(.WIDTH(W), .VALUE(V), .COUNT(255)) u_dut255 (
    .clock(clock), .reset(reset), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_bits(in_bits2), .busy(busy2), .done(done2), .pass(pass2), .mismatches(mismatches2)
`ifdef BLACK_BOX_CHECKER_CAPTURE_EN
    , .first_bad_valid(fb_valid2), .first_bad_index(fb_index2), .first_bad_bits(fb_bits2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic model_clear();
    m_run = 0; m_done = 0; m_pass = 0; m_cnt = 0; m_bad = 0;
    m_fb_valid = 0; m_fb_idx = 0; m_fb_bits = '0;
  endtask

  task automatic model_edge(input logic s, input logic v, input logic [W-1:0] b);
    if (m_run && v) begin
      if (b != W'(V)) begin
        if (!m_fb_valid) begin
          m_fb_valid = 1; m_fb_idx = m_cnt; m_fb_bits = b;
        end
        m_bad++;
      end
      m_cnt++;
      if (m_cnt == N) begin
        m_run = 0; m_done = 1; m_pass = (m_bad == 0);
      end
    end else if (!m_run && s) begin
      model_clear();
      m_run = 1;
    end
  endtask

  task automatic chk_all();
    chk("in_ready", 32'(in_ready), 32'(m_run));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("pass", 32'(pass), 32'(m_pass));
    chk("mismatches", 32'(mismatches), (m_bad > 255) ? 32'd255 : 32'(m_bad));
`ifdef BLACK_BOX_CHECKER_CAPTURE_EN
    chk("fb_valid", 32'(fb_valid), 32'(m_fb_valid));
    chk("fb_index", 32'(fb_index), 32'(m_fb_idx));
    chk("fb_bits", 32'(fb_bits), 32'(m_fb_bits));
`endif
  endtask

  // one clock: check at negedge, drive, let the edge happen, advance model, park inputs
  task automatic step(input logic s, input logic v, input logic [W-1:0] b);
    @(negedge clock);
    chk_all();
    if (busy) busy_cnt++;
    start = s; in_valid = v; in_bits = b;
    @(posedge clock);
    model_edge(s, v, b);
    #1;
    start = 0; in_valid = 0; in_bits = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    reset = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1;
    model_clear();
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_mismatches", 32'(mismatches), 0);

    // 2: clean run, stray start on the last word must be ignored
    step(1, 0, '0);
    for (int i = 0; i < N; i++) step(i == N - 1, 1, W'(V));
    @(negedge clock);
    chk("t2_done", 32'(done), 1);
    chk("t2_pass", 32'(pass), 1);
    chk("t2_mism", 32'(mismatches), 0);
    chk("t2_ready", 32'(in_ready), 0);
    chk("t2_busy", 32'(busy), 0);

    // 3: words 2 and 5 bad
    step(1, 0, '0);
    for (int i = 0; i < N; i++) step(0, 1, (i == 2 || i == 5) ? 16'h00FF : W'(V));
    @(negedge clock);
    chk("t3_pass", 32'(pass), 0);
    chk("t3_mism", 32'(mismatches), 2);
`ifdef BLACK_BOX_CHECKER_CAPTURE_EN
    chk("t3_fb_index", 32'(fb_index), 2);
    chk("t3_fb_bits", 32'(fb_bits), 32'h00FF);
    chk("t3_fb_valid", 32'(fb_valid), 1);
`endif

    // 4: in_valid toggling, start pulsed mid-run
    step(1, 0, '0);
    busy_cnt = 0;
    for (int i = 0; i < 2 * N; i++) step(i == 6, 1'(i % 2), W'(V));
    step(0, 0, '0);
    chk("t4_busy_cycles", 32'(busy_cnt), 32'(2 * N));
    chk("t4_done", 32'(done), 1);
    chk("t4_pass", 32'(pass), 1);

    // 5: reset mid-run aborts immediately
    step(1, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 16'h1234);
    @(negedge clock);
    reset = 0;
    #1;
    model_clear();
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ready", 32'(in_ready), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_mism", 32'(mismatches), 0);
    @(negedge clock);
    reset = 1;
    step(1, 0, '0);
    for (int i = 0; i < N; i++) step(0, 1, W'(V));
    @(negedge clock);
    chk("t5_pass", 32'(pass), 1);
    chk("t5_mism2", 32'(mismatches), 0);

    // randomized runs with ragged valid, occasional bad words and stray starts
    for (int r = 0; r < 6; r++) begin
      int budget;
      step(1, 0, '0);
      budget = 0;
      while (m_run && budget < 400) begin
        logic [W-1:0] b;
        b = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'(V);
        step(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), b);
        budget++;
      end
      if (m_run) chk("rand_timeout", 1, 0);
      step(0, 0, '0);
    end

    // 6: COUNT=255, all words wrong -> saturation at 255
    @(negedge clock);
    start2 = 1;
    @(negedge clock);
    start2 = 0;
    in_valid2 = 1;
    in_bits2 = 16'h0000;
    repeat (255) @(negedge clock);
    in_valid2 = 0;
    chk("t6_done", 32'(done2), 1);
    chk("t6_pass", 32'(pass2), 0);
    chk("t6_mism", 32'(mismatches2), 255);
    chk("t6_busy", 32'(busy2), 0);
    start2 = 1;
    @(negedge clock);
    start2 = 0;
    chk("t6_restart_done", 32'(done2), 0);
    chk("t6_restart_mism", 32'(mismatches2), 0);
    chk("t6_restart_busy", 32'(busy2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
